// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per producer (ALU, LSB),
// round-robin broadcast of one result per cycle, flushed on misbranch.
module cdb_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_rob_misbranch,
  input  logic              in_alu_valid,
  input  logic [TAG_W-1:0]  in_alu_tag,
  input  logic [DATA_W-1:0] in_alu_value,
  output logic              out_alu_ready,
  input  logic              in_lsb_valid,
  input  logic [TAG_W-1:0]  in_lsb_tag,
  input  logic [DATA_W-1:0] in_lsb_value,
  output logic              out_lsb_ready,
  output logic [TAG_W-1:0]  out_cdb_tag,
  output logic [DATA_W-1:0] out_cdb_value,
  output logic              out_cdb_src
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } ent_t;

  ent_t              mem_q  [2][DEPTH];
  logic [PW-1:0]     head_q [2];
  logic [PW-1:0]     head_d [2];
  logic [PW-1:0]     tail_q [2];
  logic [PW-1:0]     tail_d [2];
  logic [CW-1:0]     cnt_q  [2];
  logic [CW-1:0]     cnt_d  [2];
  logic              last_q, last_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              src_q, src_d;

  ent_t in_ent [2];
  logic in_vld [2];
  logic push   [2];
  logic pop    [2];
  logic nempty [2];
  logic go;
  logic any;
  logic gsel;
  ent_t head_ent;

  assign go        = rdy && !in_rob_misbranch;
  assign in_ent[0] = {in_alu_tag, in_alu_value};
  assign in_ent[1] = {in_lsb_tag, in_lsb_value};
  assign in_vld[0] = in_alu_valid;
  assign in_vld[1] = in_lsb_valid;

  // Ready comes from the registered count only: no pass-through.
  assign out_alu_ready = cnt_q[0] < FULL;
  assign out_lsb_ready = cnt_q[1] < FULL;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      nempty[s] = cnt_q[s] != '0;
      push[s]   = go && in_vld[s] && (cnt_q[s] < FULL)
                  && (in_ent[s].tag != '0);
    end
  end

  // last_q = 1 means the LSB won last, so ties go to the ALU.
  always_comb begin
    any  = 1'b1;
    gsel = 1'b0;
    unique case (1'b1)
      nempty[0] && nempty[1]:  gsel = ~last_q;
      nempty[0] && !nempty[1]: gsel = 1'b0;
      !nempty[0] && nempty[1]: gsel = 1'b1;
      default:                 any  = 1'b0;
    endcase
  end

  assign pop[0]   = go && any && !gsel;
  assign pop[1]   = go && any && gsel;
  assign head_ent = mem_q[gsel][head_q[gsel]];

  always_comb begin
    tag_d   = tag_q;
    value_d = value_q;
    src_d   = src_q;
    last_d  = last_q;
    for (int s = 0; s < 2; s++) begin
      head_d[s] = head_q[s];
      tail_d[s] = tail_q[s];
      cnt_d[s]  = cnt_q[s];
    end
    if (rdy && in_rob_misbranch) begin
      for (int s = 0; s < 2; s++) begin
        head_d[s] = '0;
        tail_d[s] = '0;
        cnt_d[s]  = '0;
      end
      tag_d  = '0;
      last_d = 1'b1;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) tail_d[s] = tail_q[s] + 1'b1;
        if (pop[s])  head_d[s] = head_q[s] + 1'b1;
        cnt_d[s] = cnt_q[s] + CW'(push[s]) - CW'(pop[s]);
      end
      if (any) begin
        tag_d   = head_ent.tag;
        value_d = head_ent.value;
        src_d   = gsel;
        last_d  = gsel;
      end else begin
        tag_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= '0;
        tail_q[s] <= '0;
        cnt_q[s]  <= '0;
      end
      last_q  <= 1'b1;
      tag_q   <= '0;
      value_q <= '0;
      src_q   <= 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        head_q[s] <= head_d[s];
        tail_q[s] <= tail_d[s];
        cnt_q[s]  <= cnt_d[s];
      end
      last_q  <= last_d;
      tag_q   <= tag_d;
      value_q <= value_d;
      src_q   <= src_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) mem_q[s][tail_q[s]] <= in_ent[s];
    end
  end

  assign out_cdb_tag   = tag_q;
  assign out_cdb_value = value_q;
  assign out_cdb_src   = src_q;

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares one common data bus (CDB) between two result producers: the ALU and the load/store buffer.
- Broadcasts one result per cycle to the reservation station, load/store buffer and reorder buffer.
- Each producer has its own FIFO, so a result is never lost when both producers finish in the same cycle.
- Arbitration between the two FIFOs is round-robin; the whole block is flushed on a branch misprediction.

Parameters:
DATA_W, 32, width of the result value
TAG_W, 4, ROB tag width; tag 0 means "no result / idle"
DEPTH, 4, entries per source FIFO; must be a power of two, at least 2

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global ready; when low, all state holds
in_rob_misbranch  input  1  flush request from the ROB
in_alu_valid  input  1  ALU result present this cycle
in_alu_tag  input  TAG_W  ROB tag of the ALU result
in_alu_value  input  DATA_W  ALU result value
out_alu_ready  output  1  ALU FIFO can accept an entry
in_lsb_valid  input  1  LSB result present this cycle
in_lsb_tag  input  TAG_W  ROB tag of the LSB result
in_lsb_value  input  DATA_W  LSB result value
out_lsb_ready  output  1  LSB FIFO can accept an entry
out_cdb_tag  output  TAG_W  broadcast tag; 0 means bus idle (registered)
out_cdb_value  output  DATA_W  broadcast value (registered)
out_cdb_src  output  1  source of the broadcast: 0 = ALU, 1 = LSB (registered)

Behaviour:
- Reset (rst high at a clock edge, takes priority over everything):
  - out_cdb_tag, out_cdb_value and out_cdb_src all 0.
  - Both FIFOs empty: head, tail and count all 0.
  - last_grant = LSB, so the ALU wins the first tie.
  - Reset in mid-operation discards every queued entry.
- Ready outputs: out_x_ready = (count_x < DEPTH), combinational from registered count only.
  - No pass-through: a full FIFO reports not-ready even in a cycle where it pops.
- Push, on each edge with rdy=1 and no misbranch:
  - Source x pushes when in_x_valid && out_x_ready && in_x_tag != 0.
  - Valid with tag 0 is ignored.
  - Valid while not ready is dropped; producers must hold their result until ready is seen.
- Grant, on each edge with rdy=1 and no misbranch, using FIFO state from before the edge:
  - Both FIFOs empty: out_cdb_tag <= 0; out_cdb_value and out_cdb_src hold.
  - Exactly one FIFO non-empty: pop that FIFO's head.
  - Both FIFOs non-empty: pop the source that is not last_grant.
  - On any pop: out_cdb_tag/value <= head entry, out_cdb_src <= source, last_grant <= source.
- Latency: an entry pushed into an empty FIFO at edge N is on the CDB after edge N+1 and valid for exactly one cycle.
  - There is no same-cycle bypass.
- Simultaneous push and pop on the same FIFO:
  - Allowed whenever the FIFO was not full before the edge.
  - Count is unchanged.
  - Order is strict FIFO per source.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Misbranch (in_rob_misbranch=1 with rdy=1):
  - Both FIFOs cleared.
  - out_cdb_tag <= 0.
  - last_grant <= LSB.
  - Inputs in the same cycle are dropped.
  - Broadcasting resumes the cycle after the next push.
- rdy=0:
  - No push, pop, flush or pointer change.
  - out_cdb_* hold their values; consumers are stalled by the same rdy, so a held tag is not re-consumed.
- Fairness bound: with both sources saturated, grants alternate ALU, LSB, ALU, …; no source waits more than one broadcast.

Test Plan:
- Reset then idle: out_cdb_tag=0, out_cdb_src=0, both readys=1 for 10 cycles.
- ALU pushes tag=3, value=0x12345678 at edge 1, LSB idle: after edge 2 CDB shows tag=3, value=0x12345678, src=0; after edge 3 CDB shows tag=0.
- Both sources push at edge 1: ALU tag=2, value=0xA; LSB tag=5, value=0xB. Expect CDB tag 2 (src 0), then tag 5 (src 1), then 0.
- Saturation, DEPTH=4: LSB pushes tags 1..6 on consecutive cycles while ALU holds tag=7 valid.
  - out_lsb_ready drops when the LSB count reaches 4.
  - CDB alternates 7, 1, then remaining LSB tags in order.
  - No tag is duplicated or lost, given the producer holds its result while not ready.
- Misbranch with 3 ALU and 2 LSB entries queued:
  - Cycle after the flush: out_cdb_tag=0 and both readys=1.
  - A new ALU push of tag=9 appears on the CDB after 1 further edge.
- rdy low for 3 cycles while the CDB shows tag=4 and the FIFOs hold entries:
  - Outputs and counts are frozen.
  - Draining resumes in unchanged order when rdy returns.
